// File: rtl/sram_port_arbiter.sv
// Shares the single-port data SRAM between the CPU datapath and a DMA/debug loader.
// CPU has fixed priority; DMA gets an anti-starvation escape and bounded burst locking.
module sram_port_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              locked
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_run;
  logic              r_cpu_rvalid;
  logic              r_dma_rvalid;
  logic              w_cpu_gnt;
  logic              w_dma_gnt;

  // Grant decision; r_run keeps everything idle until the first edge after reset.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (r_run) begin
      case (r_state)
        ST_NORMAL: begin
          if (dma_req && (r_wait_cnt == WAIT_SAT)) begin
            w_dma_gnt = 1'b1;
          end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else begin
            w_dma_gnt = dma_req;
          end
        end
        ST_LOCKED: begin
          w_dma_gnt = dma_req;
        end
        ST_RELEASE: begin
          if (cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else begin
            w_dma_gnt = dma_req;
          end
        end
        default: begin
          w_cpu_gnt = 1'b0;
          w_dma_gnt = 1'b0;
        end
      endcase
    end else begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
    end
  end

  // SRAM port mux: idle port drives all zeros.
  always_comb begin
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    ram_we    = 1'b0;
    if (w_cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (w_dma_gnt) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
    end else begin
      ram_we    = 1'b0;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? ram_q : {DATA_W{1'b0}};
  assign dma_rdata  = r_dma_rvalid ? ram_q : {DATA_W{1'b0}};
  assign locked     = (r_state == ST_LOCKED);

  // Lock FSM, DMA starvation counter and read-return pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_NORMAL;
      r_wait_cnt   <= {WAIT_W{1'b0}};
      r_lock_cnt   <= {LOCK_W{1'b0}};
      r_run        <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_dma_rvalid <= w_dma_gnt & ~dma_we;

      if (w_dma_gnt || !dma_req) begin
        r_wait_cnt <= {WAIT_W{1'b0}};
      end else if (r_wait_cnt != WAIT_SAT) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end

      case (r_state)
        ST_NORMAL: begin
          if (w_dma_gnt && dma_lock) begin
            r_state    <= ST_LOCKED;
            r_lock_cnt <= {LOCK_W{1'b0}};
          end else begin
            r_state    <= ST_NORMAL;
          end
        end
        ST_LOCKED: begin
          // Idle locked cycles still count toward the hold limit.
          if (!dma_lock) begin
            r_state <= ST_NORMAL;
          end else if (r_lock_cnt == LOCK_LAST) begin
            r_state <= ST_RELEASE;
          end else begin
            r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
          end
        end
        ST_RELEASE: begin
          r_state <= ST_NORMAL;
        end
        default: begin
          r_state    <= ST_NORMAL;
          r_lock_cnt <= {LOCK_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a one-cycle-latency 128x8 SRAM model.
module tb_sram_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, ram_wdata, ram_q, cpu_rdata, dma_rdata;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_we, locked;
  logic [DW-1:0] mem [0:127];
  int            n_cmp = 0;
  int            n_err = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q),
    .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 7'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 7'h00; dma_wdata = 8'h00; dma_lock = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h05; cpu_wdata = 8'hA5;
    repeat (2) @(negedge clk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %0b want 0", ram_we); end
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL rst_cpu_gnt: got %0b want 0", cpu_gnt); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL rst_dma_gnt: got %0b want 0", dma_gnt); end
    n_cmp++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %0b%0b want 00", cpu_rvalid, dma_rvalid); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %0b want 0", locked); end
    n_cmp++; if (ram_addr !== 7'h00) begin n_err++; $display("FAIL rst_ram_addr: got %0h want 0", ram_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL rel_before_edge_gnt: got %0b want 0", cpu_gnt); end
    @(negedge clk); #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rel_cpu_gnt: got %0b want 1", cpu_gnt); end
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rel_ram_we: got %0b want 1", ram_we); end
    n_cmp++; if (ram_addr !== 7'h05) begin n_err++; $display("FAIL rel_ram_addr: got %0h want 05", ram_addr); end
    // reset mid-access kills the write strobe immediately
    rst = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL mid_rst_ram_we: got %0b want 0", ram_we); end
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL mid_rst_gnt: got %0b want 0", cpu_gnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rst2_cpu_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clk);
    idle();
    n_cmp++; if (mem[5] !== 8'hA5) begin n_err++; $display("FAIL rst_write_commit: got %0h want a5", mem[5]); end
  endtask

  task automatic test_reset_read_discard();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL discard_gnt: got %0b want 1", cpu_gnt); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL discard_rvalid: got %0b want 0", cpu_rvalid); end
    idle();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h0D; cpu_wdata = 8'h5A;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rd_pre_wr_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %0b want 1", cpu_gnt); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL rd_dma_gnt: got %0b want 0", dma_gnt); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rd_ram_we: got %0b want 0", ram_we); end
    n_cmp++; if (ram_addr !== 7'h0D) begin n_err++; $display("FAIL rd_ram_addr: got %0h want 0d", ram_addr); end
    @(negedge clk);
    idle();
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %0b want 1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL rd_rdata: got %0h want 5a", cpu_rdata); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_dma_rvalid: got %0b want 0", dma_rvalid); end
    n_cmp++; if (dma_rdata !== 8'h00) begin n_err++; $display("FAIL rd_dma_rdata: got %0h want 0", dma_rdata); end
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_drop: got %0b want 0", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rd_rdata_gated: got %0h want 0", cpu_rdata); end
  endtask

  task automatic test_starvation();
    logic [5:0] exp_cpu = 6'b101111;
    logic [5:0] exp_dma = 6'b010000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (dma_rvalid !== exp_dma[i-1]) begin n_err++; $display("FAIL starve_dma_rvalid[%0d]: got %0b want %0b", i, dma_rvalid, exp_dma[i-1]); end
        n_cmp++; if (cpu_rvalid !== exp_cpu[i-1]) begin n_err++; $display("FAIL starve_cpu_rvalid[%0d]: got %0b want %0b", i, cpu_rvalid, exp_cpu[i-1]); end
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h01;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'h02;
      #1;
      n_cmp++; if (cpu_gnt !== exp_cpu[i]) begin n_err++; $display("FAIL starve_cpu_gnt[%0d]: got %0b want %0b", i, cpu_gnt, exp_cpu[i]); end
      n_cmp++; if (dma_gnt !== exp_dma[i]) begin n_err++; $display("FAIL starve_dma_gnt[%0d]: got %0b want %0b", i, dma_gnt, exp_dma[i]); end
      n_cmp++; if (ram_addr !== (exp_dma[i] ? 7'h02 : 7'h01)) begin n_err++; $display("FAIL starve_addr[%0d]: got %0h", i, ram_addr); end
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [8:0] lck  = 9'h07F;
    logic [8:0] e_cp = 9'h10F;
    logic [8:0] e_dm = 9'h0F0;
    logic [8:0] e_lk = 9'h0E0;
    int n_dma = 0;
    int n_lk  = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h03;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 7'h40; dma_wdata = 8'hC0; dma_lock = lck[i];
      #1;
      if (dma_gnt) n_dma++;
      if (locked) n_lk++;
      n_cmp++; if (cpu_gnt !== e_cp[i]) begin n_err++; $display("FAIL burst_cpu_gnt[%0d]: got %0b want %0b", i, cpu_gnt, e_cp[i]); end
      n_cmp++; if (dma_gnt !== e_dm[i]) begin n_err++; $display("FAIL burst_dma_gnt[%0d]: got %0b want %0b", i, dma_gnt, e_dm[i]); end
      n_cmp++; if (locked !== e_lk[i]) begin n_err++; $display("FAIL burst_locked[%0d]: got %0b want %0b", i, locked, e_lk[i]); end
      n_cmp++; if (ram_we !== e_dm[i]) begin n_err++; $display("FAIL burst_ram_we[%0d]: got %0b want %0b", i, ram_we, e_dm[i]); end
    end
    n_cmp++; if (n_dma !== 4) begin n_err++; $display("FAIL burst_dma_count: got %0d want 4", n_dma); end
    n_cmp++; if (n_lk !== 3) begin n_err++; $display("FAIL burst_locked_count: got %0d want 3", n_lk); end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_lock_max();
    logic [18:0] e_cp = 19'h1E00F;
    logic [18:0] e_dm = 19'h61FF0;
    logic [18:0] e_lk = 19'h41FE0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h04;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'h08; dma_lock = 1'b1;
      #1;
      n_cmp++; if (cpu_gnt !== e_cp[i]) begin n_err++; $display("FAIL lmax_cpu_gnt[%0d]: got %0b want %0b", i, cpu_gnt, e_cp[i]); end
      n_cmp++; if (dma_gnt !== e_dm[i]) begin n_err++; $display("FAIL lmax_dma_gnt[%0d]: got %0b want %0b", i, dma_gnt, e_dm[i]); end
      n_cmp++; if (locked !== e_lk[i]) begin n_err++; $display("FAIL lmax_locked[%0d]: got %0b want %0b", i, locked, e_lk[i]); end
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lmax_unlock: got %0b want 0", locked); end
  endtask

  task automatic test_lock_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_req = (i > 0); cpu_we = 1'b0; cpu_addr = 7'h06;
      dma_req = (i == 0); dma_we = 1'b1; dma_addr = 7'h09; dma_wdata = 8'h3C; dma_lock = 1'b1;
      #1;
      n_cmp++; if (cpu_gnt !== (i == 9)) begin n_err++; $display("FAIL lidle_cpu_gnt[%0d]: got %0b", i, cpu_gnt); end
      n_cmp++; if (dma_gnt !== (i == 0)) begin n_err++; $display("FAIL lidle_dma_gnt[%0d]: got %0b", i, dma_gnt); end
      n_cmp++; if (locked !== (i >= 1 && i <= 8)) begin n_err++; $display("FAIL lidle_locked[%0d]: got %0b", i, locked); end
      n_cmp++; if (ram_we !== (i == 0)) begin n_err++; $display("FAIL lidle_ram_we[%0d]: got %0b", i, ram_we); end
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h20; cpu_wdata = 8'h11;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_wr_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_rd_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clk);
    idle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 7'h20; dma_wdata = 8'h77;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid: got %0b want 1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 8'h11) begin n_err++; $display("FAIL b2b_old_data: got %0h want 11", cpu_rdata); end
    #1;
    n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_dma_gnt: got %0b want 1", dma_gnt); end
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL b2b_dma_we: got %0b want 1", ram_we); end
    n_cmp++; if (ram_wdata !== 8'h77) begin n_err++; $display("FAIL b2b_dma_wdata: got %0h want 77", ram_wdata); end
    @(negedge clk);
    idle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h20;
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_wr_no_rvalid: got %0b want 0", dma_rvalid); end
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_rd2_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clk);
    idle();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'h20;
    n_cmp++; if (cpu_rdata !== 8'h77) begin n_err++; $display("FAIL b2b_new_data: got %0h want 77", cpu_rdata); end
    #1;
    n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_dma_rd_gnt: got %0b want 1", dma_gnt); end
    @(negedge clk);
    idle();
    n_cmp++; if (dma_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_dma_rvalid: got %0b want 1", dma_rvalid); end
    n_cmp++; if (dma_rdata !== 8'h77) begin n_err++; $display("FAIL b2b_dma_rdata: got %0h want 77", dma_rdata); end
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_cpu_rvalid: got %0b want 0", cpu_rvalid); end
  endtask

  initial begin
    test_reset();
    test_reset_read_discard();
    test_cpu_read();
    test_starvation();
    test_burst();
    test_lock_max();
    test_lock_idle();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
